// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer and full-flag controller for the async FIFO (write clock domain).
// Optional almost_full output is enabled by defining FIFO_WR_ALMOST_FULL_EN.
module fifo_wr_ptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow
`ifdef FIFO_WR_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  logic [ADDR_WIDTH:0] wr_bin;
  logic [ADDR_WIDTH:0] wr_bin_next;
  logic [ADDR_WIDTH:0] wr_gray_next;
  logic [ADDR_WIDTH:0] rd_bin_sync;
  logic [ADDR_WIDTH:0] full_gray;
  logic [ADDR_WIDTH:0] level_next;

  assign wr_en        = push && !full;
  assign wr_addr      = wr_bin[ADDR_WIDTH-1:0];
  assign wr_bin_next  = wr_bin + {{ADDR_WIDTH{1'b0}}, wr_en};
  assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin_sync = '0;
    for (int unsigned i = 0; i <= ADDR_WIDTH; i++) begin
      rd_bin_sync[i] = ^(rd_ptr_gray_sync >> i);
    end
  end

  // Full when write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_gray  = {~rd_ptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                       rd_ptr_gray_sync[ADDR_WIDTH-2:0]};
  assign level_next = wr_bin_next - rd_bin_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      level       <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_ptr_gray <= wr_gray_next;
      full        <= (wr_gray_next == full_gray);
      level       <= level_next;
      if (push && full)
        overflow <= 1'b1;
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      almost_full <= 1'b0;
    else
      almost_full <= (level_next >= (ADDR_WIDTH+1)'(AF_LEVEL));
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Directed self-checking bench for fifo_wr_ptr_full at ADDR_WIDTH=2.
// Covers almost_full too when built with FIFO_WR_ALMOST_FULL_EN.
module tb_fifo_wr_ptr_full;

  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          push;
  logic [AW:0]   rd_ptr_gray_sync;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_ptr_gray;
  logic          full;
  logic [AW:0]   level;
  logic          overflow;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic          almost_full;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_ptr_full #(
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .push             (push),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .level            (level),
    .overflow         (overflow)
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    .almost_full      (almost_full)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW:0] to_gray(input int unsigned b);
    logic [AW:0] v;
    v = AW'(b) | ((AW+1)'(b) & (AW+1)'(1 << AW));
    v = (AW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    push  = 1'b0;
    rd_ptr_gray_sync = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  logic [AW:0] fill_gray [4];

  initial begin
    fill_gray[0] = 3'b001; fill_gray[1] = 3'b011;
    fill_gray[2] = 3'b010; fill_gray[3] = 3'b110;

    rst_n = 1'b1; push = 1'b0; rd_ptr_gray_sync = '0;
    #2;
    do_reset;
    check("rst_gray",  wr_ptr_gray, 0);
    check("rst_full",  full, 0);
    check("rst_level", level, 0);
    check("rst_ovf",   overflow, 0);
    check("rst_wren",  wr_en, 0);
    check("rst_addr",  wr_addr, 0);

    // Fill all four entries
    for (int k = 0; k < 4; k++) begin
      push = 1'b1;
      #1;
      check($sformatf("fill_wren%0d", k), wr_en, 1);
      check($sformatf("fill_addr%0d", k), wr_addr, k);
      tick;
      check($sformatf("fill_gray%0d", k), wr_ptr_gray, fill_gray[k]);
      check($sformatf("fill_lvl%0d", k), level, k + 1);
      check($sformatf("fill_full%0d", k), full, (k == 3) ? 1 : 0);
      check($sformatf("fill_ovf%0d", k), overflow, 0);
    end

    // Push while full
    #1;
    check("ovf_wren", wr_en, 0);
    tick;
    check("ovf_gray", wr_ptr_gray, 3'b110);
    check("ovf_set",  overflow, 1);
    check("ovf_full", full, 1);
    check("ovf_lvl",  level, 4);
    push = 1'b0;
    tick;
    check("ovf_sticky", overflow, 1);

    // Reader frees one entry
    rd_ptr_gray_sync = 3'b001;
    tick;
    check("free_full", full, 0);
    check("free_lvl",  level, 3);
    push = 1'b1;
    #1;
    check("refill_wren", wr_en, 1);
    check("refill_addr", wr_addr, 0);
    tick;
    check("refill_gray", wr_ptr_gray, 3'b111);
    check("refill_full", full, 1);
    check("refill_lvl",  level, 4);
    push = 1'b0;

    // Asynchronous reset between edges with wr_bin=5
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gray",  wr_ptr_gray, 0);
    check("arst_full",  full, 0);
    check("arst_level", level, 0);
    check("arst_ovf",   overflow, 0);
    tick;
    rd_ptr_gray_sync = '0;
    rst_n = 1'b1;
    tick;

    // Wrap: 9 pushes with reader trailing
    for (int k = 0; k < 9; k++) begin
      push = 1'b1;
      rd_ptr_gray_sync = to_gray((k > 0) ? k - 1 : 0);
      #1;
      check($sformatf("wrap_addr%0d", k), wr_addr, k % 4);
      check($sformatf("wrap_wren%0d", k), wr_en, 1);
      tick;
      check($sformatf("wrap_gray%0d", k), wr_ptr_gray, to_gray((k + 1) % 8));
      check($sformatf("wrap_full%0d", k), full, 0);
      check($sformatf("wrap_lvl%0d", k), level, (k == 0) ? 1 : 2);
    end
    push = 1'b0;

`ifdef FIFO_WR_ALMOST_FULL_EN
    do_reset;
    check("af_rst", almost_full, 0);
    for (int k = 0; k < 3; k++) begin
      push = 1'b1;
      tick;
      check($sformatf("af_flag%0d", k), almost_full, (k == 2) ? 1 : 0);
      check($sformatf("af_full%0d", k), full, 0);
    end
    push = 1'b0;
`endif

    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ptr_full.md
Name: fifo_wr_ptr_full

Overview:
Write-side pointer and full-flag controller for the async FIFO, running entirely in the write clock domain. Accepts push requests and generates the RAM write strobe and address. Produces the registered Gray-coded write pointer that feeds the 2-flop pointer synchronizer into the read domain. Consumes the already-synchronized read Gray pointer to derive full, fill level and a sticky overflow error.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AF_LEVEL, 2**ADDR_WIDTH-1, almost_full threshold in entries (used only with FIFO_WR_ALMOST_FULL_EN).

Ports:
clk  input  1  write-domain clock
rst_n  input  1  asynchronous active-low reset
push  input  1  write request; data accepted this cycle iff push && !full
rd_ptr_gray_sync  input  ADDR_WIDTH+1  read pointer (Gray), already synchronized into clk domain
wr_en  output  1  RAM write strobe, combinational = push && !full
wr_addr  output  ADDR_WIDTH  RAM write address = wr_bin[ADDR_WIDTH-1:0]
wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer
full  output  1  registered full flag
level  output  ADDR_WIDTH+1  registered fill level as seen by write domain
overflow  output  1  sticky: set on push while full
almost_full  output  1  registered; present only with FIFO_WR_ALMOST_FULL_EN

Behaviour:
- Reset (async assert, sync-to-clk deassert by upstream): wr_bin=0, wr_ptr_gray=0, full=0, level=0, overflow=0, almost_full=0. wr_en follows push && !full (0 during reset since no push expected; not gated by rst_n).
- wr_bin_next = wr_bin + (push && !full), modulo 2**(ADDR_WIDTH+1); natural wrap, no saturation.
- wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1); wr_ptr_gray registers wr_gray_next every edge. Only the registered Gray value leaves the block; never a combinational value.
- Full: full <= (wr_gray_next == {~rd_ptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_ptr_gray_sync[ADDR_WIDTH-2:0]}). Full therefore asserts on the same edge as the pointer update that fills the last entry, and deasserts one cycle after rd_ptr_gray_sync advances.
- Full is conservative: the synchronized read pointer lags, so full may stay high after the reader frees space; full is never low while the FIFO is truly full.
- rd_bin_sync = Gray-to-binary of rd_ptr_gray_sync (XOR prefix from MSB), combinational.
- level <= wr_bin_next - rd_bin_sync, computed at ADDR_WIDTH+1 bits modulo; range 0..2**ADDR_WIDTH.
- Push while full: wr_en=0, pointers unchanged, overflow <= 1. Overflow clears only on reset.
- push held across full→not-full: accepted in the first cycle full is sampled low.
- Reset mid-operation: all state returns to reset values immediately; no partial pointer update.

Optional Feature:
FIFO_WR_ALMOST_FULL_EN: when defined, almost_full port exists; almost_full <= (wr_bin_next - rd_bin_sync) >= AF_LEVEL, same timing as level. When undefined, port and its logic are absent; all other behaviour identical.

Test Plan:
- ADDR_WIDTH=2, reset, rd_ptr_gray_sync=000, push 4 cycles -> wr_addr 0,1,2,3 with wr_en=1; wr_ptr_gray 001,011,010,110; full=1 and level=4 after 4th edge.
- Continue push on 5th cycle while full -> wr_en=0, wr_ptr_gray stays 110, overflow=1 and remains 1 afterwards.
- From full, set rd_ptr_gray_sync=001 -> next edge full=0, level=3; push that cycle -> wr_addr=0, wr_ptr_gray=111, full=1 after edge.
- Wrap: stream 9 pushes with rd_ptr_gray_sync tracking writes 2 behind -> wr_bin 7→0, wr_ptr_gray 100→000, full never asserts, level=2 throughout steady state.
- Assert rst_n=0 mid-stream (wr_bin=5) asynchronously, between edges -> wr_ptr_gray, full, level, overflow all 0 immediately, before next clk edge.
- With FIFO_WR_ALMOST_FULL_EN, AF_LEVEL=3, rd sync=000: 3 pushes -> almost_full=1 after 3rd edge, full=0; without macro, build has no almost_full port.
